// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA256 widths, digest/word types and the word slice helper
package sha256_pkg;
  localparam int SHA256_DIGEST_W = 256;
  localparam int SHA256_WORD_W = 32;
  localparam int SHA256_WORDS = 8;
  typedef logic [SHA256_DIGEST_W-1:0] digest_t;
  typedef logic [SHA256_WORD_W-1:0] word_t;
  typedef logic [$clog2(SHA256_WORDS)-1:0] widx_t;
  // word k of a digest in send order; msw=1 starts at H0 (bits 255:224)
  function automatic word_t word_sel(digest_t d, widx_t k, logic msw);
    word_t [SHA256_WORDS-1:0] w;
    w = d;
    return w[msw ? ~k : k];
  endfunction
endpackage

// File: rtl/sha256_digest_buf.sv
// sha256_digest_buf: DEPTH x 256-bit circular digest buffer with push/pop/full handling
module sha256_digest_buf
  import sha256_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_req,
  input  digest_t                wr_data,
  input  logic                   pop,
  output digest_t                rd_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   drop
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  digest_t mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic push;
  // a full buffer still accepts a digest when the head leaves on the same edge
  always_comb begin
    push = wr_req & ((level_q != LW'(DEPTH)) | pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    level_d = level_q + LW'(push) - LW'(pop);
  end
  // pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
    end
  end
  // digest storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end
  assign rd_data = mem_q[rd_ptr_q];
  assign level = level_q;
  assign drop = wr_req & ~push;
endmodule

// File: rtl/sha256_digest_ser.sv
// sha256_digest_ser: buffers SHA256 digests and streams them as 8 x 32-bit words; SHA256_SER_DROP_CNT_EN adds drop_cnt/drop_clr
module sha256_digest_ser
  import sha256_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter bit MSW_FIRST = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   d_valid,
  input  logic [255:0]           d_data,
  output logic                   o_valid,
  output logic [31:0]            o_data,
  output logic                   o_last,
  input  logic                   o_ready,
  output logic                   d_drop,
  output logic [$clog2(DEPTH):0] level
`ifdef SHA256_SER_DROP_CNT_EN
  ,
  input  logic                   drop_clr,
  output logic [7:0]             drop_cnt
`endif
);
  digest_t rd_data;
  widx_t cnt_q, cnt_d;
  logic d_drop_q, d_drop_d;
  logic xfer, pop, drop;
  sha256_digest_buf #(.DEPTH(DEPTH)) u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_req  (d_valid),
    .wr_data (d_data),
    .pop     (pop),
    .rd_data (rd_data),
    .level   (level),
    .drop    (drop)
  );
  assign o_valid = level != '0;
  assign xfer = o_valid & o_ready;
  assign pop = xfer & (&cnt_q);
  assign o_data = o_valid ? word_sel(rd_data, cnt_q, MSW_FIRST) : '0;
  assign o_last = o_valid & (&cnt_q);
  assign d_drop = d_drop_q;
  // word counter advances per transfer and wraps into the next digest
  always_comb begin
    cnt_d = cnt_q + widx_t'(xfer);
    d_drop_d = drop;
  end
  // word counter and drop pulse registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
      d_drop_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      d_drop_q <= d_drop_d;
    end
  end
`ifdef SHA256_SER_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;
  // saturating drop count; clear wins over an increment
  always_comb begin
    drop_cnt_d = drop_clr ? 8'd0 : (d_drop_q && drop_cnt_q != 8'hff) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end
  // drop count register
  always_ff @(posedge clk) begin
    if (!reset_n) drop_cnt_q <= '0;
    else drop_cnt_q <= drop_cnt_d;
  end
  assign drop_cnt = drop_cnt_q;
`endif
endmodule
